// File: rtl/debounce_array.sv
// Multi-channel key debouncer: 2-flop synchroniser, stability counter,
// edge-selectable press pulse and one-shot long-press pulse per channel.
module debounce_array #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_VAL    = 500_000,
    parameter int unsigned LONG_VAL   = 50_000_000,
    parameter int unsigned ACTIVE_LOW = 1,
    parameter int unsigned EDGE_MODE  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] key_in,
    output logic [N_CH-1:0] key_level,
    output logic [N_CH-1:0] key_press,
    output logic [N_CH-1:0] key_long
);

    localparam int unsigned     CW        = $clog2(CNT_VAL) + 1;
    localparam int unsigned     LW        = $clog2(LONG_VAL) + 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CNT_VAL - 1);
    localparam logic [LW-1:0]   LONG_MAX  = LW'(LONG_VAL);
    localparam logic [LW-1:0]   LONG_LAST = LW'(LONG_VAL - 1);
    localparam logic [N_CH-1:0] IDLE      = {N_CH{ACTIVE_LOW != 0}};

    logic [N_CH-1:0] r_meta;
    logic [N_CH-1:0] r_sync;
    logic [N_CH-1:0] r_level;
    logic [N_CH-1:0] r_press;
    logic [N_CH-1:0] r_long;
    logic [CW-1:0]   r_cnt  [N_CH];
    logic [LW-1:0]   r_lcnt [N_CH];

    logic [N_CH-1:0] w_norm;
    logic [N_CH-1:0] w_diff;
    logic [N_CH-1:0] w_accept;
    logic [N_CH-1:0] w_pulse;

    always_comb begin
        w_norm   = (ACTIVE_LOW != 0) ? ~r_sync : r_sync;
        w_diff   = w_norm ^ r_level;
        w_accept = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
        case (EDGE_MODE)
            0:       w_pulse = w_accept & w_norm;
            1:       w_pulse = w_accept & ~w_norm;
            default: w_pulse = w_accept;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta  <= IDLE;
            r_sync  <= IDLE;
            r_level <= '0;
            r_press <= '0;
            r_long  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i]  <= '0;
                r_lcnt[i] <= '0;
            end
        end else begin
            r_meta  <= key_in;
            r_sync  <= r_meta;
            r_level <= r_level ^ w_accept;
            r_press <= w_pulse;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
                // Saturation at LONG_MAX guarantees a single pulse per press.
                if (!r_level[i]) begin
                    r_lcnt[i] <= '0;
                end else if (r_lcnt[i] != LONG_MAX) begin
                    r_lcnt[i] <= r_lcnt[i] + 1'b1;
                end
                r_long[i] <= r_level[i] && (r_lcnt[i] == LONG_LAST);
            end
        end
    end

    assign key_level = r_level;
    assign key_press = r_press;
    assign key_long  = r_long;

endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array: window-based reference model checked every cycle
// on three instances (EDGE_MODE 0/1/2) plus directed literal expectations.
module tb_debounce_array;

    localparam int unsigned N    = 4;
    localparam int unsigned CNT  = 8;
    localparam int unsigned LONG = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_in;
    logic [N-1:0] lvl [3];
    logic [N-1:0] prs [3];
    logic [N-1:0] lng [3];

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    always #5 clk = ~clk;

    debounce_array #(.N_CH(N), .CNT_VAL(CNT), .LONG_VAL(LONG), .ACTIVE_LOW(1), .EDGE_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_level(lvl[0]), .key_press(prs[0]), .key_long(lng[0]));
    debounce_array #(.N_CH(N), .CNT_VAL(CNT), .LONG_VAL(LONG), .ACTIVE_LOW(1), .EDGE_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_level(lvl[1]), .key_press(prs[1]), .key_long(lng[1]));
    debounce_array #(.N_CH(N), .CNT_VAL(CNT), .LONG_VAL(LONG), .ACTIVE_LOW(1), .EDGE_MODE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_level(lvl[2]), .key_press(prs[2]), .key_long(lng[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a level is accepted once the last CNT synchronised
    // samples (input delayed two edges) all oppose it; long press fires
    // exactly LONG edges after the rise while the level is still high.
    logic [N-1:0]     m_level = '0;
    logic [N-1:0]     m_long  = '0;
    logic [N-1:0]     m_press [3];
    logic [CNT-1:0]   m_hist  [N];
    int unsigned      m_rise  [N];
    logic [N-1:0]     m_p0, m_p1;
    bit               m_valid = 1'b0;
    int unsigned      cyc = 0;

    initial begin
        logic use_v, new_v;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_valid = 1'b1;
                m_p0 = '0;
                m_p1 = '0;
                m_level = '0;
                m_long = '0;
                for (int k = 0; k < 3; k++) m_press[k] = '0;
                for (int c = 0; c < N; c++) m_hist[c] = '0;
            end else begin
                for (int c = 0; c < N; c++) begin
                    use_v = m_p1[c];
                    m_p1[c] = m_p0[c];
                    m_p0[c] = ~key_in[c];
                    m_hist[c] = {m_hist[c][CNT-2:0], use_v};
                    m_long[c] = m_level[c] && ((cyc - m_rise[c]) == LONG);
                    if (m_hist[c] == {CNT{~m_level[c]}}) begin
                        new_v = ~m_level[c];
                        m_level[c] = new_v;
                        m_press[0][c] = new_v;
                        m_press[1][c] = ~new_v;
                        m_press[2][c] = 1'b1;
                        if (new_v) m_rise[c] = cyc;
                    end else begin
                        for (int k = 0; k < 3; k++) m_press[k][c] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("model_level%0d", k), 32'(lvl[k]), 32'(m_level));
                    chk($sformatf("model_press%0d", k), 32'(prs[k]), 32'(m_press[k]));
                    chk($sformatf("model_long%0d", k),  32'(lng[k]), 32'(m_long));
                end
            end
        end
    end

    initial begin
        int unsigned cnt, pos;
        int unsigned pc [3];
        int unsigned pf [3];
        int unsigned pl [3];

        rst_n  = 1'b0;
        key_in = '1;
        tick(3);
        chk("rst_level", 32'(lvl[0]), 32'h0);
        chk("rst_press", 32'(prs[0]), 32'h0);
        chk("rst_long",  32'(lng[0]), 32'h0);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_level", 32'(lvl[0] | lvl[2]), 32'h0);

        // clean press on ch0
        key_in[0] = 1'b0;
        tick(9);
        chk("press_edge9_level", 32'(lvl[0]), 32'h0);
        tick(1);
        chk("press_edge10_level", 32'(lvl[0]), 32'h1);
        chk("press_edge10_pulse", 32'(prs[0]), 32'h1);
        tick(1);
        chk("press_edge11_pulse", 32'(prs[0]), 32'h0);
        key_in[0] = 1'b1;
        tick(12);

        // bounce on ch1, last toggle lands on pressed
        for (int i = 0; i <= 8; i++) begin
            key_in[1] = (i % 2 == 1);
            if (i != 8) begin
                tick(5);
                chk("bounce_level", 32'(lvl[0][1]), 32'h0);
            end
        end
        tick(9);
        chk("bounce_edge9_level", 32'(lvl[0][1]), 32'h0);
        tick(1);
        chk("bounce_edge10_level", 32'(lvl[0][1]), 32'h1);
        chk("bounce_edge10_pulse", 32'(prs[0][1]), 32'h1);
        key_in[1] = 1'b1;
        tick(12);

        // long press on ch2
        cnt = 0;
        pos = 0;
        key_in[2] = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            tick(1);
            if (lng[0][2]) begin
                cnt++;
                pos = t;
            end
        end
        chk("long_count", cnt, 1);
        chk("long_pos", pos, 42);
        key_in[2] = 1'b1;
        tick(12);

        // short press on ch2: no long pulse
        cnt = 0;
        key_in[2] = 1'b0;
        for (int t = 1; t <= 65; t++) begin
            tick(1);
            if (t == 20) key_in[2] = 1'b1;
            if (lng[0][2]) cnt++;
        end
        chk("short_long_count", cnt, 0);

        // edge modes on ch3
        for (int k = 0; k < 3; k++) begin
            pc[k] = 0;
            pf[k] = 0;
            pl[k] = 0;
        end
        key_in[3] = 1'b0;
        for (int t = 1; t <= 50; t++) begin
            tick(1);
            if (t == 20) key_in[3] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (prs[k][3]) begin
                    pc[k]++;
                    if (pf[k] == 0) pf[k] = t;
                    pl[k] = t;
                end
            end
        end
        chk("mode0_count", pc[0], 1);
        chk("mode0_pos",   pf[0], 10);
        chk("mode1_count", pc[1], 1);
        chk("mode1_pos",   pf[1], 30);
        chk("mode2_count", pc[2], 2);
        chk("mode2_first", pf[2], 10);
        chk("mode2_last",  pl[2], 30);

        // reset mid-count on ch0
        key_in[0] = 1'b0;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(9);
        chk("rstmid_edge9_level", 32'(lvl[0][0]), 32'h0);
        tick(1);
        chk("rstmid_edge10_level", 32'(lvl[0][0]), 32'h1);
        chk("rstmid_edge10_pulse", 32'(prs[0][0]), 32'h1);
        key_in[0] = 1'b1;
        tick(12);

        // simultaneous ch0+ch1
        key_in[1:0] = 2'b00;
        tick(10);
        chk("simul_pulse", 32'(prs[0]), 32'h3);
        chk("simul_level", 32'(lvl[0]), 32'h3);
        key_in = '1;
        tick(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
